// File: rtl/sa_sum_sequencer.sv
// sa_sum_sequencer: per-point clear/issue/drain/publish control for the delay-and-sum path.
module sa_sum_sequencer #(
    parameter int NUM_CHANNELS = 4,
    parameter int NUM_POINTS   = 64,
    parameter int RD_LATENCY   = 2,
    parameter int CH_W         = $clog2(NUM_CHANNELS),
    parameter int PT_W         = NUM_POINTS > 1 ? $clog2(NUM_POINTS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            frame_start,
    input  logic            abort,
    input  logic            out_ready,
    output logic            rd_en,
    output logic [CH_W-1:0] ch_sel,
    output logic [PT_W-1:0] pt_idx,
    output logic            start_sum,
    output logic            sum_en,
    output logic            done_channel,
    output logic            busy,
    output logic            frame_done
);
    localparam int DC_W = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_RDY, CLEAR, ISSUE, DRAIN, FINISH} state_t;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [PT_W-1:0]       pt_q, pt_d;
    logic [DC_W-1:0]       dc_q, dc_d;
    logic [RD_LATENCY-1:0] sr_q, sr_d;
    logic                  rd_q, rd_d, ss_q, ss_d, dn_q, dn_d, busy_q, busy_d, fd_q, fd_d;
    logic                  last_ch, last_pt, last_dc;

    assign last_ch = ch_q == CH_W'(NUM_CHANNELS - 1);
    assign last_pt = pt_q == PT_W'(NUM_POINTS - 1);
    assign last_dc = dc_q == DC_W'(RD_LATENCY - 1);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        pt_d    = pt_q;
        dc_d    = dc_q;
        case (state_q)
            IDLE: begin
                state_d = frame_start ? WAIT_RDY : IDLE;
                pt_d    = frame_start ? '0 : pt_q;
            end
            WAIT_RDY: state_d = out_ready ? CLEAR : WAIT_RDY;
            CLEAR: begin
                state_d = ISSUE;
                ch_d    = '0;
            end
            ISSUE: begin
                state_d = last_ch ? DRAIN : ISSUE;
                ch_d    = last_ch ? ch_q : ch_q + CH_W'(1);
                dc_d    = '0;
            end
            DRAIN: begin
                state_d = last_dc ? FINISH : DRAIN;
                dc_d    = dc_q + DC_W'(1);
            end
            FINISH: begin
                state_d = last_pt ? IDLE : WAIT_RDY;
                pt_d    = last_pt ? pt_q : pt_q + PT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        // abort overrides every transition, including a frame_start seen in IDLE
        if (abort) state_d = IDLE;
        rd_d   = state_d == ISSUE;
        ss_d   = state_d == CLEAR;
        dn_d   = state_d == FINISH;
        busy_d = state_d != IDLE;
        fd_d   = state_q == FINISH && last_pt && !abort;
        sr_d   = abort ? '0 : RD_LATENCY'({sr_q, rd_q});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ch_q    <= '0;
            pt_q    <= '0;
            dc_q    <= '0;
            sr_q    <= '0;
            rd_q    <= 1'b0;
            ss_q    <= 1'b0;
            dn_q    <= 1'b0;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            pt_q    <= pt_d;
            dc_q    <= dc_d;
            sr_q    <= sr_d;
            rd_q    <= rd_d;
            ss_q    <= ss_d;
            dn_q    <= dn_d;
            busy_q  <= busy_d;
            fd_q    <= fd_d;
        end
    end

    assign rd_en        = rd_q;
    assign ch_sel       = ch_q;
    assign pt_idx       = pt_q;
    assign start_sum    = ss_q;
    assign sum_en       = sr_q[RD_LATENCY-1];
    assign done_channel = dn_q;
    assign busy         = busy_q;
    assign frame_done   = fd_q;
endmodule

// File: tb/tb_sa_sum_sequencer.sv
// tb_sa_sum_sequencer: directed vectors plus corner sequences on a 4ch/RL2 and an 8ch/RL1 instance.
module tb_sa_sum_sequencer;
    logic clk = 1'b0;
    logic reset, frame_start, abort, out_ready;
    logic rd_en_a, ss_a, se_a, dc_a, bz_a, fd_a;
    logic [1:0] ch_a;
    logic [0:0] pt_a;
    logic rd_en_b, ss_b, se_b, dc_b, bz_b, fd_b;
    logic [2:0] ch_b;
    logic [0:0] pt_b;

    int checks = 0, failures = 0;
    int cyc = 0, ss_cyc_a = 0, ss_cyc_b = 0;
    int dcnt_a = 0, dcnt_b = 0, fdc_a = 0, fdc_b = 0;
    logic [15:0] a_s1 = 0, a_s2 = 0, acc_a = 0, b_s1 = 0, acc_b = 0;

    sa_sum_sequencer #(.NUM_CHANNELS(4), .NUM_POINTS(2), .RD_LATENCY(2)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .abort(abort), .out_ready(out_ready),
        .rd_en(rd_en_a), .ch_sel(ch_a), .pt_idx(pt_a), .start_sum(ss_a), .sum_en(se_a),
        .done_channel(dc_a), .busy(bz_a), .frame_done(fd_a));

    sa_sum_sequencer #(.NUM_CHANNELS(8), .NUM_POINTS(2), .RD_LATENCY(1)) dut8 (
        .clk(clk), .reset(reset), .frame_start(frame_start), .abort(abort), .out_ready(out_ready),
        .rd_en(rd_en_b), .ch_sel(ch_b), .pt_idx(pt_b), .start_sum(ss_b), .sum_en(se_b),
        .done_channel(dc_b), .busy(bz_b), .frame_done(fd_b));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // delay-buffer model returns 10*(ch+1) after the read latency; accumulator favours sum_en over clear
    always @(posedge clk) begin
        cyc++;
        a_s1 <= rd_en_a ? 16'(10 * (ch_a + 1)) : 16'd0;
        a_s2 <= a_s1;
        b_s1 <= rd_en_b ? 16'(10 * (ch_b + 1)) : 16'd0;
        if (se_a) acc_a <= acc_a + a_s2;
        else if (ss_a) acc_a <= 16'd0;
        if (se_b) acc_b <= acc_b + b_s1;
        else if (ss_b) acc_b <= 16'd0;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (ss_a || se_a) chk("excl_a", {31'd0, ss_a && se_a}, 0);
            if (ss_b || se_b) chk("excl_b", {31'd0, ss_b && se_b}, 0);
            if (dc_a) begin
                chk("acc_a", acc_a, 100);
                chk("lat_a", cyc - ss_cyc_a + 1, 8);
                dcnt_a++;
            end
            if (dc_b) begin
                chk("acc_b", acc_b, 360);
                chk("lat_b", cyc - ss_cyc_b + 1, 11);
                dcnt_b++;
            end
            if (ss_a) ss_cyc_a = cyc;
            if (ss_b) ss_cyc_b = cyc;
            if (fd_a) fdc_a++;
            if (fd_b) fdc_b++;
        end
    end

    typedef struct {
        logic fs, ab, rdy, rd;
        logic [1:0] ch;
        logic pt, ss, se, dc, bz, fd;
    } vec_t;

    function automatic vec_t mk(input logic fs, ab, rdy, rd, input logic [1:0] ch,
                                input logic pt, ss, se, dc, bz, fd);
        vec_t v;
        v.fs = fs; v.ab = ab; v.rdy = rdy; v.rd = rd; v.ch = ch;
        v.pt = pt; v.ss = ss; v.se = se; v.dc = dc; v.bz = bz; v.fd = fd;
        return v;
    endfunction

    vec_t vec [20];

    initial begin
        int n;
        logic seen;
        // each row: inputs for one cycle, outputs expected after the following edge
        vec[0]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        vec[1]  = mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
        vec[2]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0);
        vec[3]  = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0);
        vec[4]  = mk(0, 0, 1, 1, 2, 0, 0, 1, 0, 1, 0);
        vec[5]  = mk(1, 0, 1, 1, 3, 0, 0, 1, 0, 1, 0);
        vec[6]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        vec[7]  = mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        vec[8]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        vec[9]  = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 0);
        vec[10] = mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0);
        vec[11] = mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0);
        vec[12] = mk(0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0);
        vec[13] = mk(0, 0, 1, 1, 2, 1, 0, 1, 0, 1, 0);
        vec[14] = mk(0, 0, 1, 1, 3, 1, 0, 1, 0, 1, 0);
        vec[15] = mk(0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0);
        vec[16] = mk(0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0);
        vec[17] = mk(0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0);
        vec[18] = mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        vec[19] = mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);

        reset = 1; frame_start = 0; abort = 0; out_ready = 1;
        repeat (3) step();
        chk("rst_a", {rd_en_a, ch_a, pt_a, ss_a, se_a, dc_a, bz_a, fd_a}, 0);
        chk("rst_b", {rd_en_b, ch_b, pt_b, ss_b, se_b, dc_b, bz_b, fd_b}, 0);
        reset = 0;

        for (int i = 0; i < 20; i++) begin
            frame_start = vec[i].fs; abort = vec[i].ab; out_ready = vec[i].rdy;
            step();
            chk($sformatf("v%0d_rd", i), rd_en_a, vec[i].rd);
            chk($sformatf("v%0d_ss", i), ss_a, vec[i].ss);
            chk($sformatf("v%0d_se", i), se_a, vec[i].se);
            chk($sformatf("v%0d_dc", i), dc_a, vec[i].dc);
            chk($sformatf("v%0d_bz", i), bz_a, vec[i].bz);
            chk($sformatf("v%0d_fd", i), fd_a, vec[i].fd);
            if (vec[i].rd) chk($sformatf("v%0d_ch", i), ch_a, vec[i].ch);
            if (vec[i].bz) chk($sformatf("v%0d_pt", i), pt_a, vec[i].pt);
        end
        frame_start = 0; abort = 0;
        chk("abort_start_b", bz_b, 0);

        // out_ready stall after the first point
        frame_start = 1; step(); frame_start = 0;
        n = 0;
        while (!dc_a && n < 50) begin step(); n++; end
        chk("stall_wait_done", dc_a, 1);
        out_ready = 0;
        repeat (5) begin
            step();
            chk("stall_hold", {bz_a, rd_en_a, ss_a, se_a, dc_a, pt_a}, 6'b100001);
        end
        out_ready = 1;
        step();
        chk("resume_ss", ss_a, 1);
        chk("resume_pt", pt_a, 1);
        n = 0;
        while (!fd_a && n < 30) begin step(); n++; end
        chk("stall_frame_done", fd_a, 1);
        n = 0;
        while (bz_b && n < 50) begin step(); n++; end
        chk("stall_b_idle", bz_b, 0);
        step();

        // abort during the second ISSUE cycle
        frame_start = 1; step(); frame_start = 0;
        n = 0;
        while (!(rd_en_a && ch_a == 2'd1) && n < 20) begin step(); n++; end
        chk("abort_wait_issue", {rd_en_a, ch_a}, 3'b101);
        abort = 1;
        step();
        abort = 0;
        chk("abort_idle_a", {bz_a, rd_en_a, ss_a, se_a, dc_a, fd_a}, 0);
        chk("abort_idle_b", {bz_b, rd_en_b, ss_b, se_b, dc_b, fd_b}, 0);
        seen = 0;
        repeat (15) begin
            step();
            seen = seen | dc_a | fd_a | se_a | bz_a | dc_b | fd_b | se_b | bz_b;
        end
        chk("abort_quiet", seen, 0);

        // reset in DRAIN, then a full line with a stray frame_start mid-line
        frame_start = 1; step(); frame_start = 0;
        n = 0;
        while (!(rd_en_a && ch_a == 2'd3) && n < 20) begin step(); n++; end
        step();
        chk("drain_state", {rd_en_a, se_a, dc_a}, 3'b010);
        reset = 1;
        step();
        chk("rst_drain_a", {rd_en_a, ch_a, pt_a, ss_a, se_a, dc_a, bz_a, fd_a}, 0);
        chk("rst_drain_b", {rd_en_b, ch_b, pt_b, ss_b, se_b, dc_b, bz_b, fd_b}, 0);
        reset = 0;
        step();
        dcnt_a = 0; dcnt_b = 0; fdc_a = 0; fdc_b = 0;
        frame_start = 1; step(); frame_start = 0;
        chk("restart_busy", bz_a, 1);
        chk("restart_pt", pt_a, 0);
        repeat (4) step();
        frame_start = 1; step(); frame_start = 0;
        n = 0;
        while ((fdc_a == 0 || fdc_b == 0) && n < 100) begin step(); n++; end
        step();
        chk("line_done_a", dcnt_a, 2);
        chk("line_done_b", dcnt_b, 2);
        chk("line_fd_a", fdc_a, 1);
        chk("line_fd_b", fdc_b, 1);
        chk("line_idle", {bz_a, bz_b}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
